// File: rtl/psram_arbiter.sv
// ---------------------------------------------------------------------------
// psram_arbiter
//
// Shares the single PSRAM controller among NREQ bus masters (video fetch,
// CPU, DMA). A winner is chosen by fixed-plus-round-robin or pure
// round-robin priority. Its command is latched and held stable towards the
// controller for the whole transfer. The arbiter sequences the controller's
// strobe/busy/done handshake, returns read data and pulses a one-cycle
// acknowledge to the granted requester. A watchdog aborts a transfer the
// controller never finishes and raises a sticky error flag.
//
// Parameters
//   NREQ     number of requesters (2..4)
//   PRIO0    1: requester 0 has absolute priority, others round-robin
//            0: all requesters round-robin
//   TIMEOUT  cycles from strobe to done before the transfer is aborted
//
// Ports
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_req            per-requester request, held until its o_ack
//   i_we             per-requester write enable
//   i_addr           per-requester 24-bit word address, packed by index
//   i_din            per-requester 16-bit write data, packed by index
//   o_ack            one-cycle completion pulse to the granted requester
//   o_rdata          read data, valid with o_ack, held until the next read
//   o_err            sticky timeout flag
//   o_gnt            index of the current / last granted requester
//   o_mem_*          command to the PSRAM controller
//   i_mem_busy       controller busy
//   i_mem_done       controller done (level, high while idle after a transfer)
//   i_mem_dout       controller read data
// ---------------------------------------------------------------------------
module psram_arbiter #(
    parameter int NREQ    = 3,
    parameter bit PRIO0   = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_we,
    input  logic [24*NREQ-1:0] i_addr,
    input  logic [16*NREQ-1:0] i_din,
    output logic [NREQ-1:0]    o_ack,
    output logic [15:0]        o_rdata,
    output logic               o_err,
    output logic [1:0]         o_gnt,
    output logic               o_mem_stb,
    output logic               o_mem_we,
    output logic [23:0]        o_mem_addr,
    output logic [15:0]        o_mem_din,
    input  logic               i_mem_busy,
    input  logic               i_mem_done,
    input  logic [15:0]        i_mem_dout
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ACCEPT,
        XFER,
        RELEASE
    } state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [7:0]      count;

    logic [1:0]      win;
    logic            win_rr;
    logic [1:0]      idx;
    logic            timed_out;
    logic [NREQ-1:0] ack_onehot;

    // Winner selection. Requester 0 pre-empts everything when PRIO0 is set;
    // otherwise the first requesting port after the round-robin pointer
    // wins. win_rr doubles as the "found" flag so the first hit is kept.
    always_comb begin
        win    = '0;
        win_rr = 1'b0;
        idx    = '0;
        if (PRIO0 && i_req[0]) begin
            win = '0;
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                idx = 2'((int'(rr_ptr) + i) % NREQ);
                if (!win_rr && i_req[idx] && !(PRIO0 && idx == 2'd0)) begin
                    win    = idx;
                    win_rr = 1'b1;
                end
            end
        end
    end

    assign timed_out  = (count == 8'(TIMEOUT));
    assign ack_onehot = {{(NREQ-1){1'b0}}, 1'b1} << o_gnt;

    // Main sequencer. Every output is a register so the controller and
    // the requesters only ever see glitch-free signals. The command
    // registers are only written on a grant, so they stay constant until
    // the next one. The watchdog counts in ACCEPT and XFER, and an
    // expired count always wins over the normal handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= INIT;
            o_ack      <= '0;
            o_rdata    <= '0;
            o_err      <= 1'b0;
            o_gnt      <= '0;
            o_mem_stb  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
            rr_ptr     <= 2'(NREQ - 1);
            count      <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (i_mem_done && !i_mem_busy) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (|i_req) begin
                        o_gnt      <= win;
                        o_mem_we   <= i_we[win];
                        o_mem_addr <= i_addr[24*int'(win) +: 24];
                        o_mem_din  <= i_din[16*int'(win) +: 16];
                        o_mem_stb  <= 1'b1;
                        count      <= '0;
                        if (win_rr) begin
                            rr_ptr <= win;
                        end
                        state <= ACCEPT;
                    end
                end

                ACCEPT: begin
                    o_mem_stb <= 1'b0;
                    if (timed_out) begin
                        o_err <= 1'b1;
                        o_ack <= ack_onehot;
                        state <= RELEASE;
                    end else begin
                        count <= count + 8'd1;
                        if (i_mem_busy) begin
                            state <= XFER;
                        end
                    end
                end

                XFER: begin
                    if (timed_out) begin
                        o_err <= 1'b1;
                        o_ack <= ack_onehot;
                        state <= RELEASE;
                    end else begin
                        count <= count + 8'd1;
                        if (i_mem_done && !i_mem_busy) begin
                            if (!o_mem_we) begin
                                o_rdata <= i_mem_dout;
                            end
                            o_ack <= ack_onehot;
                            state <= RELEASE;
                        end
                    end
                end

                // One dead cycle so the acknowledged requester can drop
                // i_req before IDLE samples the requests again.
                RELEASE: begin
                    o_ack <= '0;
                    state <= IDLE;
                end

                default: begin
                    state     <= INIT;
                    o_mem_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Shares the single PSRAM controller among up to NREQ requesters (video fetch, CPU, DMA) and sequences each access through the controller's strobe/busy/done handshake. Wins a requester by fixed or round-robin priority, latches its command, holds it stable for the whole transfer, returns read data and a one-cycle acknowledge. Sits between the bus masters and the PSRAM controller; it is the only master of that controller.

## Interface
- NREQ, 3: number of requesters (2..4).
- PRIO0, 1: 1 = requester 0 has absolute priority, others round-robin; 0 = all round-robin.
- TIMEOUT, 255: max cycles from strobe to done before abort (8-bit counter).
- i_clk  in  1  system clock (100 MHz).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NREQ  per-requester request; held until its o_ack.
- i_we  in  NREQ  per-requester write enable (1 = write).
- i_addr  in  24*NREQ  per-requester word address, requester k at [24k+23:24k].
- i_din  in  16*NREQ  per-requester write data, requester k at [16k+15:16k].
- o_ack  out  NREQ  one-cycle completion pulse to granted requester.
- o_rdata  out  16  read data, valid in o_ack cycle, held until next read completes.
- o_err  out  1  sticky timeout flag, cleared only by reset.
- o_gnt  out  2  index of current/last granted requester.
- o_mem_stb  out  1  strobe to controller.
- o_mem_we  out  1  controller write enable.
- o_mem_addr  out  24  controller address.
- o_mem_din  out  16  controller write data.
- i_mem_busy  in  1  controller busy.
- i_mem_done  in  1  controller done (level, high while controller idle after a transfer).
- i_mem_dout  in  16  controller read data.

## Operation
- States: INIT, IDLE, ACCEPT, XFER, RELEASE.
- Reset: state INIT; o_ack=0, o_rdata=0, o_err=0, o_gnt=0, o_mem_stb=0, o_mem_we=0, o_mem_addr=0, o_mem_din=0, rr pointer=NREQ-1, timeout count=0.
- INIT: wait for controller power-up; exit to IDLE when i_mem_done=1 and i_mem_busy=0. Requests ignored.
- IDLE: if any i_req bit set, select winner: with PRIO0=1 and i_req[0]=1, winner=0; else first set bit searching from rr+1 upward, wrapping modulo NREQ (with PRIO0=1, index 0 skipped in this search). Latch winner's i_we/i_addr/i_din into o_mem_*; o_gnt=winner; o_mem_stb<=1; count<=0; go ACCEPT. Round-robin pointer updates to winner only for round-robin grants.
- ACCEPT: o_mem_stb<=0 (strobe high exactly one cycle). When i_mem_busy=1 go XFER.
- XFER: when i_mem_done=1 and i_mem_busy=0: if o_mem_we=0, o_rdata<=i_mem_dout; o_ack[o_gnt]<=1; go RELEASE.
- RELEASE: o_ack<=0; go IDLE. Requests are not sampled here, giving the acked requester one cycle to drop i_req.
- o_mem_we/addr/din stay constant from grant until next grant.
- Timeout: count increments each cycle in ACCEPT and XFER; at count=TIMEOUT, set o_err, pulse o_ack[o_gnt] with o_rdata unchanged, go RELEASE.
- Requests changing on non-granted ports during a transfer have no effect until next IDLE.
- i_rst_n low in any state, including mid-transfer: immediate return to reset values; strobe never left high.

## Timing
- Request seen in IDLE -> o_mem_stb high next cycle (1-cycle grant latency).
- Controller asserts busy 1 cycle after strobe; ACCEPT normally lasts 1 cycle.
- o_ack high the cycle after the controller's done edge; 1 idle cycle (RELEASE) between transfers, so back-to-back grants are spaced by transfer time + 3 cycles.
- Requester must deassert i_req (or present a new command) by the RELEASE cycle; a still-asserted req is treated as a new request.

## Test plan
- Reset then controller holds busy=1 for 20000 cycles: no o_mem_stb while busy/done=0; first stb only after done=1, busy=0.
- Single read, req[1], addr 0x012345, model returns 0xBEEF: o_mem_stb one cycle with addr 0x012345, we=0; o_ack=3'b010 one cycle; o_rdata=0xBEEF.
- Write from req[2], addr 0xFFFFFF, din 0xA55A: o_mem_we=1, o_mem_din=0xA55A held through XFER; o_rdata unchanged; o_ack[2] pulse.
- PRIO0=1, req=3'b111 held continuously re-asserted: grant order 0,0,0 while req[0] stays high; drop req[0] -> grants alternate 1,2,1,2.
- PRIO0=0, req=3'b111 continuously: grant order 0,1,2,0 from reset pointer.
- Controller never asserts done after strobe: o_err=1 and o_ack pulse at TIMEOUT cycles; assert i_rst_n=0 mid-XFER -> all outputs to reset values same cycle.
